// File: rtl/seq_controller.sv
// Stage sequencer and PC-update controller for the Y86-64 sequential core.
// Walks each instruction through six one-cycle stages and owns the architectural PC.
module seq_controller #(
  parameter int           n        = 64,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [3:0]   icode,
  input  logic [n-1:0] valC,
  input  logic [n-1:0] valP,
  input  logic         instr_valid,
  input  logic         imem_error,
  input  logic         halt,
  input  logic         cnd,
  input  logic [n-1:0] valM,
  input  logic         dmem_error,
  output logic [n-1:0] PC,
  output logic [2:0]   stage,
  output logic         fetch_en,
  output logic         decode_en,
  output logic         exec_en,
  output logic         mem_en,
  output logic         wb_en,
  output logic [2:0]   stat,
  output logic         retired,
  output logic [31:0]  instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    PCUPD  = 3'd6,
    STOP   = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t       state;
  state_t       nxt;
  logic [3:0]   icode_q;
  logic [n-1:0] valc_q;
  logic [n-1:0] valp_q;
  logic [n-1:0] valm_q;
  logic         cnd_q;
  logic [n-1:0] next_pc;

  assign stage = state;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = run ? FETCH : IDLE;
      FETCH:  nxt = (imem_error || !instr_valid || halt) ? STOP : DECODE;
      DECODE: nxt = EXEC;
      EXEC:   nxt = MEM;
      MEM:    nxt = dmem_error ? STOP : WB;
      WB:     nxt = PCUPD;
      PCUPD:  nxt = run ? FETCH : IDLE;
      STOP:   nxt = STOP;
      default: nxt = IDLE;
    endcase
  end

  // Next-PC selection works only from the copies captured during the instruction.
  always_comb begin
    next_pc = valp_q;
    case (icode_q)
      4'd7:    next_pc = cnd_q ? valc_q : valp_q;
      4'd8:    next_pc = valc_q;
      4'd9:    next_pc = valm_q;
      default: next_pc = valp_q;
    endcase
  end

  // Strobes and retired are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      stat        <= STAT_AOK;
      instr_count <= '0;
      fetch_en    <= 1'b0;
      decode_en   <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      retired     <= 1'b0;
      icode_q     <= '0;
      valc_q      <= '0;
      valp_q      <= '0;
      valm_q      <= '0;
      cnd_q       <= 1'b0;
    end else begin
      state     <= nxt;
      fetch_en  <= (nxt == FETCH);
      decode_en <= (nxt == DECODE);
      exec_en   <= (nxt == EXEC);
      mem_en    <= (nxt == MEM);
      wb_en     <= (nxt == WB);
      retired   <= (nxt == PCUPD);
      case (state)
        FETCH: begin
          if (imem_error)        stat <= STAT_ADR;
          else if (!instr_valid) stat <= STAT_INS;
          else if (halt)         stat <= STAT_HLT;
          else begin
            icode_q <= icode;
            valc_q  <= valC;
            valp_q  <= valP;
          end
        end
        EXEC: cnd_q <= cnd;
        MEM: begin
          if (dmem_error) stat   <= STAT_ADR;
          else            valm_q <= valM;
        end
        PCUPD: begin
          PC          <= next_pc;
          instr_count <= instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Directed self-checking bench for seq_controller: stage walk, next-PC choices,
// halt/error stops, run handshake and mid-instruction reset.
module tb_seq_controller;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  icode;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic        halt;
  logic        cnd;
  logic [63:0] valM;
  logic        dmem_error;
  logic [63:0] PC;
  logic [2:0]  stage;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic [2:0]  stat;
  logic        retired;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;

  seq_controller #(.n(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .icode(icode), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error), .halt(halt), .cnd(cnd),
    .valM(valM), .dmem_error(dmem_error), .PC(PC), .stage(stage),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en),
    .wb_en(wb_en), .stat(stat), .retired(retired), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] expEnables(input logic [2:0] s);
    case (s)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                               input logic valid, input logic ierr, input logic hlt,
                               input logic c, input logic [63:0] vm, input logic derr);
    icode = ic; valC = vc; valP = vp; instr_valid = valid; imem_error = ierr;
    halt = hlt; cnd = c; valM = vm; dmem_error = derr;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    run   = 1'b0;
    tick();
    checkOutput("rst_stage", 64'(stage), 64'd0);
    checkOutput("rst_pc", PC, 64'h0);
    checkOutput("rst_stat", 64'(stat), 64'd1);
    checkOutput("rst_count", 64'(instr_count), 64'd0);
    checkOutput("rst_en", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, retired}), 64'd0);
    rst_n = 1'b1;
  endtask

  // Starts and ends sampled in FETCH with run=1; fetch inputs are scrambled after FETCH
  // and cnd/valM after their capture cycles, so only the captured copies can matter.
  task automatic doInstr(input string tag, input logic [3:0] ic, input logic [63:0] vc,
                         input logic [63:0] vp, input logic c, input logic [63:0] vm,
                         input logic [63:0] exp_pc);
    applyStimulus(ic, vc, vp, 1'b1, 1'b0, 1'b0, c, vm, 1'b0);
    tick();
    icode = ~ic; valC = ~vc; valP = ~vp;
    tick();
    tick();
    cnd = ~c;
    tick();
    valM = ~vm;
    tick();
    checkOutput({tag, "_retired"}, 64'(retired), 64'd1);
    tick();
    checkOutput({tag, "_stage"}, 64'(stage), 64'd1);
    checkOutput({tag, "_pc"}, PC, exp_pc);
  endtask

  initial begin
    logic [2:0] seq [6];
    seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    applyStimulus(4'd1, 64'h0, 64'h1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

    // nop walk through every stage
    doReset();
    run = 1'b1;
    tick();
    checkOutput("nop_fetch", 64'(stage), 64'd1);
    checkOutput("nop_fetch_en", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 64'(expEnables(3'd1)));
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("nop_stage%0d", i), 64'(stage), 64'(seq[i]));
      checkOutput($sformatf("nop_en%0d", i), 64'({fetch_en, decode_en, exec_en, mem_en, wb_en}),
                  64'(expEnables(seq[i])));
      checkOutput($sformatf("nop_ret%0d", i), 64'(retired), (seq[i] == 3'd6) ? 64'd1 : 64'd0);
    end
    checkOutput("nop_pc", PC, 64'h1);
    checkOutput("nop_count", 64'(instr_count), 64'd1);

    // control flow: call, jXX taken / not taken, call, ret
    doInstr("call10", 4'd8, 64'h10, 64'hA, 1'b0, 64'h0, 64'h10);
    doInstr("jxx_t", 4'd7, 64'h40, 64'h19, 1'b1, 64'h0, 64'h40);
    doInstr("call10b", 4'd8, 64'h10, 64'h49, 1'b1, 64'h0, 64'h10);
    doInstr("jxx_nt", 4'd7, 64'h40, 64'h19, 1'b0, 64'h0, 64'h19);
    doInstr("call80", 4'd8, 64'h80, 64'h22, 1'b0, 64'h0, 64'h80);
    doInstr("ret", 4'd9, 64'h55, 64'h81, 1'b0, 64'h20, 64'h20);
    checkOutput("flow_count", 64'(instr_count), 64'd7);

    // halt at 0x5, then run pulses in STOP
    doInstr("to5", 4'd1, 64'h0, 64'h5, 1'b0, 64'h0, 64'h5);
    applyStimulus(4'd0, 64'h0, 64'h6, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("halt_stage", 64'(stage), 64'd7);
    checkOutput("halt_stat", 64'(stat), 64'd2);
    checkOutput("halt_pc", PC, 64'h5);
    checkOutput("halt_ret", 64'(retired), 64'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    checkOutput("stop_stage", 64'(stage), 64'd7);
    checkOutput("stop_count", 64'(instr_count), 64'd8);
    checkOutput("stop_en", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, retired}), 64'd0);

    // imem_error wins over invalid instruction
    doReset();
    run = 1'b1;
    tick();
    applyStimulus(4'd1, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("imem_stage", 64'(stage), 64'd7);
    checkOutput("imem_stat", 64'(stat), 64'd3);

    // invalid instruction alone
    doReset();
    run = 1'b1;
    tick();
    applyStimulus(4'd1, 64'h0, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    checkOutput("ins_stage", 64'(stage), 64'd7);
    checkOutput("ins_stat", 64'(stat), 64'd4);

    // dmem_error in MEM
    doReset();
    run = 1'b1;
    tick();
    doInstr("to8", 4'd1, 64'h0, 64'h8, 1'b0, 64'h0, 64'h8);
    applyStimulus(4'd5, 64'h0, 64'h9, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    tick(); tick(); tick();
    checkOutput("dmem_in_mem", 64'(stage), 64'd4);
    tick();
    checkOutput("dmem_stage", 64'(stage), 64'd7);
    checkOutput("dmem_stat", 64'(stat), 64'd3);
    checkOutput("dmem_pc", PC, 64'h8);
    checkOutput("dmem_count", 64'(instr_count), 64'd1);
    checkOutput("dmem_ret", 64'(retired), 64'd0);

    // drop run during EXEC, instruction still completes
    doReset();
    run = 1'b1;
    tick();
    applyStimulus(4'd1, 64'h0, 64'h3, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick(); tick();
    checkOutput("drop_exec", 64'(stage), 64'd3);
    run = 1'b0;
    tick(); tick(); tick();
    checkOutput("drop_pcupd", 64'(stage), 64'd6);
    checkOutput("drop_ret", 64'(retired), 64'd1);
    tick();
    checkOutput("drop_idle", 64'(stage), 64'd0);
    checkOutput("drop_pc", PC, 64'h3);
    checkOutput("drop_count", 64'(instr_count), 64'd1);
    tick();
    checkOutput("drop_stay", 64'(stage), 64'd0);
    run = 1'b1;
    tick();
    checkOutput("rerun_fetch", 64'(stage), 64'd1);

    // reset in MEM with PC=0x30, count=5
    doReset();
    run = 1'b1;
    tick();
    doInstr("r1", 4'd1, 64'h0, 64'h1, 1'b0, 64'h0, 64'h1);
    doInstr("r2", 4'd1, 64'h0, 64'h2, 1'b0, 64'h0, 64'h2);
    doInstr("r3", 4'd1, 64'h0, 64'h3, 1'b0, 64'h0, 64'h3);
    doInstr("r4", 4'd1, 64'h0, 64'h4, 1'b0, 64'h0, 64'h4);
    doInstr("r5", 4'd1, 64'h0, 64'h30, 1'b0, 64'h0, 64'h30);
    checkOutput("pre_count", 64'(instr_count), 64'd5);
    applyStimulus(4'd1, 64'h0, 64'h38, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    tick(); tick(); tick();
    checkOutput("pre_mem", 64'(stage), 64'd4);
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_stage", 64'(stage), 64'd0);
    checkOutput("mrst_pc", PC, 64'h0);
    checkOutput("mrst_count", 64'(instr_count), 64'd0);
    checkOutput("mrst_stat", 64'(stat), 64'd1);
    checkOutput("mrst_ret", 64'(retired), 64'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Stage sequencer and PC-update controller for the Y86-64 sequential core.
- Steps one instruction at a time through the fetch, decode, execute, memory, writeback and PC-update stages, one cycle per stage.
- Owns the architectural PC and drives it into fetch.
- Selects the next PC, converts fetch and memory errors into the Y86 status code, and stops the machine on halt or error.

Parameters:
- n, 64, address/data width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
- icode  input  4  from fetch.
- valC  input  n  from fetch.
- valP  input  n  from fetch.
- instr_valid  input  1  from fetch.
- imem_error  input  1  from fetch.
- halt  input  1  from fetch.
- cnd  input  1  branch condition from execute.
- valM  input  n  value read by memory stage.
- dmem_error  input  1  from memory stage.
- PC  output  n  current instruction address, to fetch.
- stage  output  3  current state encoding.
- fetch_en, decode_en, exec_en, mem_en, wb_en  output  1 each  stage strobes.
- stat  output  3  status code: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- retired  output  1  one-cycle pulse per completed instruction.
- instr_count  output  32  number of retired instructions.

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUPD=6, STOP=7.
  - stage outputs the current state encoding.
- Reset:
  - When rst_n=0 at a rising edge, regardless of state: state=IDLE, PC=RESET_PC, stat=AOK(1), instr_count=0.
  - All enables and retired are 0 during and after reset.
  - Reset mid-instruction abandons that instruction; no PC update and no count.
- IDLE:
  - All enables 0.
  - run=1 -> FETCH next cycle; run=0 -> stay in IDLE.
- FETCH:
  - fetch_en=1.
  - Fetch outputs are sampled at the end of this cycle; fetch is combinational from PC.
  - Exit checks, in priority order:
    - imem_error -> stat=ADR(3), go to STOP.
    - else instr_valid=0 -> stat=INS(4), go to STOP.
    - else halt -> stat=HLT(2), go to STOP.
    - else -> DECODE.
  - On any of these exits, PC is held and retired is not pulsed.
  - icode, valC and valP are registered internally at FETCH exit.
  - Later stages use only the registered copies, so fetch inputs may change after FETCH.
- DECODE, EXEC, WB:
  - Assert the matching enable for one cycle, then advance to the next state.
  - cnd is registered at the end of EXEC.
- MEM:
  - mem_en=1.
  - dmem_error=1 at end of cycle -> stat=ADR(3), go to STOP; no PC update, no count.
  - Otherwise valM is registered and the state advances to WB.
- PCUPD, next-PC selection from the registered values:
  - icode 7 (jXX): cnd ? valC : valP.
  - icode 8 (call): valC.
  - icode 9 (ret): valM.
  - all other icodes: valP.
- PCUPD, other actions:
  - PC loads the selected value.
  - retired=1 for this cycle only.
  - instr_count increments and wraps at 2^32-1 -> 0.
  - run=1 -> FETCH; run=0 -> IDLE.
  - run is sampled only here and in IDLE; deasserting run mid-instruction completes that instruction.
- STOP:
  - Terminal state; all enables 0.
  - PC, stat and instr_count are frozen.
  - run is ignored; only reset leaves STOP.
- Enable rules:
  - Enables are one-hot or all zero; exactly one is high in states FETCH through WB.
  - No enable is high in PCUPD, IDLE or STOP.
- Latency:
  - 6 cycles per instruction from FETCH entry to the next FETCH entry.
  - The first FETCH is the cycle after the one in which IDLE samples run=1.
- Width: all PC arithmetic is n bits, with no carry-out. valP is supplied by fetch; the controller performs no addition.

Test Plan:
- Reset, then run=1 with nop at 0 (icode 1, valP=1) → stage sequence 1,2,3,4,5,6,1. PC=1 after PCUPD, retired pulses once, instr_count=1.
- jXX at PC=0x10 with valC=0x40, valP=0x19 → PC=0x40 when cnd=1 and PC=0x19 when cnd=0. Also call with valC=0x80 → PC=0x80, and ret with valM=0x20 → PC=0x20.
- halt at PC=0x5 → stat=2, state=7, PC stays 0x5, retired never pulses. Pulsing run while in STOP leaves the state at 7.
- Error priority and memory error:
  - imem_error=1 together with instr_valid=0 → stat=3.
  - instr_valid=0 alone → stat=4.
  - dmem_error=1 in MEM → stat=3, PC unchanged, instr_count unchanged.
- Drop run during EXEC → instruction completes: PCUPD, retired=1, then IDLE. Reassert run → FETCH on the next cycle.
- Assert rst_n=0 during MEM with PC=0x30 and instr_count=5 → next cycle state=0, PC=RESET_PC, instr_count=0, stat=1, no retired pulse.
